add_round_key_stage: RTL and testbench

- AddRoundKey stage directly downstream of the column-mixing stage in the AES round datapath.
- Captures the 128-bit state on an enable pulse, normally the upstream done.
- Assembles the 128-bit round key from four 32-bit words streamed from the key-schedule unit over a valid/ready handshake.
- Registers state XOR key and pulses done for the next stage.

---
 rtl/add_round_key_stage_if.sv | 16 +
 rtl/add_round_key_stage.sv | 97 +++++++++
 tb/tb_add_round_key_stage.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/add_round_key_stage_if.sv
// add_round_key_stage_if: state/key handshake and result bundle for the AddRoundKey stage.
interface add_round_key_stage_if;
    logic [127:0] state;
    logic         enable;
    logic [31:0]  key_word;
    logic         key_valid;
    logic         key_ready;
    logic [127:0] state_out;
    logic         done;
    logic         busy;
    logic         err;
    modport master (output state, enable, key_word, key_valid,
                    input  key_ready, state_out, done, busy, err);
    modport slave  (input  state, enable, key_word, key_valid,
                    output key_ready, state_out, done, busy, err);
endinterface

// File: rtl/add_round_key_stage.sv
// add_round_key_stage: captures the state, assembles a streamed round key, registers state ^ key and pulses done.
// Define ARK_ERR_FLAG_EN to build the sticky protocol-error flag on err (tied low otherwise).
module add_round_key_stage #(
    parameter int KEY_WORDS = 4
) (
    input logic                  clk,
    input logic                  rst,
    add_round_key_stage_if.slave bus
);
    localparam int KW = KEY_WORDS * 32;
    localparam int CW = $clog2(KEY_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_APPLY} fsm_t;

    fsm_t          fsm_q, fsm_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          key_full_q, key_full_d;
    logic [KW-1:0] key_buf_q, key_buf_d;
    logic [127:0]  state_buf_q, state_buf_d;
    logic [127:0]  state_out_q, state_out_d;
    logic          done_q, done_d;
    logic          key_ready_now, accept, last;

    always_comb begin
        key_ready_now = !key_full_q && fsm_q != S_APPLY;
        accept        = bus.key_valid && key_ready_now;
        last          = accept && cnt_q == CW'(KEY_WORDS - 1);
        fsm_d         = fsm_q;
        cnt_d         = accept ? (last ? '0 : cnt_q + 1'b1) : cnt_q;
        key_full_d    = key_full_q | last;
        key_buf_d     = key_buf_q;
        if (accept) key_buf_d[cnt_q*32 +: 32] = bus.key_word;
        state_buf_d   = (fsm_q == S_IDLE && bus.enable) ? bus.state : state_buf_q;
        state_out_d   = state_out_q;
        done_d        = 1'b0;
        // a 4th word landing on this edge counts as a full key for the transition
        if (fsm_q == S_IDLE && bus.enable) fsm_d = (key_full_q || last) ? S_APPLY : S_WAIT;
        else if (fsm_q == S_WAIT && (key_full_q || last)) fsm_d = S_APPLY;
        else if (fsm_q == S_APPLY) begin
            fsm_d       = S_IDLE;
            state_out_d = state_buf_q ^ key_buf_q;
            done_d      = 1'b1;
            key_full_d  = 1'b0;
            cnt_d       = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm_q       <= S_IDLE;
            cnt_q       <= '0;
            key_full_q  <= 1'b0;
            key_buf_q   <= '0;
            state_buf_q <= '0;
            state_out_q <= '0;
            done_q      <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            cnt_q       <= cnt_d;
            key_full_q  <= key_full_d;
            key_buf_q   <= key_buf_d;
            state_buf_q <= state_buf_d;
            state_out_q <= state_out_d;
            done_q      <= done_d;
        end
    end

    assign bus.key_ready = key_ready_now;
    assign bus.state_out = state_out_q;
    assign bus.done      = done_q;
    assign bus.busy      = fsm_q != S_IDLE;

`ifdef ARK_ERR_FLAG_EN
    logic [3:0] stall_q, stall_d;
    logic       err_q, err_d;

    // stall_q saturates at 8 so the 9th consecutive refused cycle raises err
    always_comb begin
        stall_d = (bus.key_valid && !key_ready_now) ? (stall_q == 4'd8 ? stall_q : stall_q + 4'd1) : 4'd0;
        err_d   = err_q | (bus.enable && fsm_q != S_IDLE) | (stall_q == 4'd8 && bus.key_valid && !key_ready_now);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q <= 4'd0;
            err_q   <= 1'b0;
        end else begin
            stall_q <= stall_d;
            err_q   <= err_d;
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif
endmodule

// File: tb/tb_add_round_key_stage.sv
// tb_add_round_key_stage: directed scenarios plus randomized rounds checked against a transaction-level XOR model.
module tb_add_round_key_stage;
`ifdef ARK_ERR_FLAG_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   passed = 0;
    int   total = 0;
    logic prev_done = 1'b0;

    always #5 clk = ~clk;

    add_round_key_stage_if bus ();
    add_round_key_stage dut (.clk(clk), .rst(rst), .bus(bus.slave));

    function automatic logic [127:0] model(input logic [127:0] s, input logic [31:0] w0, w1, w2, w3);
        return s ^ {w3, w2, w1, w0};
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        if (bus.done) begin
            total++;
            if (prev_done) $display("FAIL done_pulse: done high 2 cycles running, required single cycle");
            else passed++;
        end
        prev_done = bus.done;
    endtask

    task automatic send_word(input logic [31:0] w);
        bus.key_valid = 1'b1;
        bus.key_word  = w;
        for (int k = 0; k < 20 && !bus.key_ready; k++) tick();
        if (!bus.key_ready) begin
            total++;
            $display("FAIL send_word_timeout: key_ready=%b, required 1 within 20 cycles", bus.key_ready);
        end
        tick();
        bus.key_valid = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst = 1'b0;
        tick();
        tick();
        total++; if (bus.state_out !== 128'h0) $display("FAIL reset_state_out: got %h required 0", bus.state_out); else passed++;
        total++; if (bus.done !== 1'b0) $display("FAIL reset_done: got %b required 0", bus.done); else passed++;
        total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b required 0", bus.busy); else passed++;
        total++; if (bus.err !== 1'b0) $display("FAIL reset_err: got %b required 0", bus.err); else passed++;
        total++; if (bus.key_ready !== 1'b1) $display("FAIL reset_key_ready: got %b required 1", bus.key_ready); else passed++;
        rst = 1'b1;
        tick();
    endtask

    task automatic test_fips();
        logic [31:0] w[4] = '{32'h2a6c7605, 32'h23a33939, 32'h88542cb1, 32'ha0fafe17};
        for (int i = 0; i < 4; i++) send_word(w[i]);
        total++; if (bus.key_ready !== 1'b0) $display("FAIL fips_key_full: key_ready=%b required 0", bus.key_ready); else passed++;
        bus.enable = 1'b1;
        bus.state  = 128'h046681e5e0cb199a48f8d37a2806264c;
        tick();
        bus.enable = 1'b0;
        total++; if (bus.busy !== 1'b1 || bus.done !== 1'b0) $display("FAIL fips_apply: busy=%b done=%b required 1/0", bus.busy, bus.done); else passed++;
        tick();
        total++; if (bus.done !== 1'b1) $display("FAIL fips_done: got %b required 1", bus.done); else passed++;
        total++; if (bus.state_out !== 128'ha49c7ff2689f352b6b5bea43026a5049) $display("FAIL fips_result: got %h required a49c7ff2689f352b6b5bea43026a5049", bus.state_out); else passed++;
        tick();
        total++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) $display("FAIL fips_after: done=%b busy=%b required 0/0", bus.done, bus.busy); else passed++;
        total++; if (bus.state_out !== 128'ha49c7ff2689f352b6b5bea43026a5049) $display("FAIL fips_hold: got %h required a49c7ff2689f352b6b5bea43026a5049", bus.state_out); else passed++;
    endtask

    task automatic test_state_first();
        logic [31:0] w[4] = '{32'h1, 32'h0, 32'h0, 32'h0};
        bus.enable = 1'b1;
        bus.state  = '1;
        tick();
        bus.enable = 1'b0;
        total++; if (bus.busy !== 1'b1) $display("FAIL sf_busy: got %b required 1", bus.busy); else passed++;
        tick();
        tick();
        total++; if (bus.done !== 1'b0 || bus.key_ready !== 1'b1) $display("FAIL sf_wait: done=%b key_ready=%b required 0/1", bus.done, bus.key_ready); else passed++;
        for (int i = 0; i < 4; i++) begin
            bus.key_valid = 1'b1;
            bus.key_word  = w[i];
            tick();
        end
        bus.key_valid = 1'b0;
        total++; if (bus.done !== 1'b0 || bus.key_ready !== 1'b0 || bus.busy !== 1'b1) $display("FAIL sf_apply: done=%b key_ready=%b busy=%b required 0/0/1", bus.done, bus.key_ready, bus.busy); else passed++;
        tick();
        total++; if (bus.done !== 1'b1) $display("FAIL sf_done: got %b required 1", bus.done); else passed++;
        total++; if (bus.state_out !== model('1, w[0], w[1], w[2], w[3])) $display("FAIL sf_result: got %h required %h", bus.state_out, model('1, w[0], w[1], w[2], w[3])); else passed++;
        tick();
        total++; if (bus.done !== 1'b0) $display("FAIL sf_done_clear: got %b required 0", bus.done); else passed++;
    endtask

    task automatic test_key_reuse();
        logic [127:0] s = {$urandom, $urandom, $urandom, $urandom};
        logic [31:0]  w[4];
        for (int i = 0; i < 4; i++) w[i] = $urandom;
        bus.enable = 1'b1;
        bus.state  = s;
        tick();
        bus.enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            total++; if (bus.done !== 1'b0 || bus.busy !== 1'b1 || bus.key_ready !== 1'b1) $display("FAIL reuse_wait: done=%b busy=%b key_ready=%b required 0/1/1", bus.done, bus.busy, bus.key_ready); else passed++;
            tick();
        end
        for (int i = 0; i < 4; i++) send_word(w[i]);
        tick();
        total++; if (bus.done !== 1'b1 || bus.state_out !== model(s, w[0], w[1], w[2], w[3])) $display("FAIL reuse_result: done=%b got %h required %h", bus.done, bus.state_out, model(s, w[0], w[1], w[2], w[3])); else passed++;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [127:0] a = {$urandom, $urandom, $urandom, $urandom};
        logic [127:0] b = ~a;
        logic [31:0]  w[4];
        int           dones = 0;
        for (int i = 0; i < 4; i++) w[i] = $urandom;
        bus.enable = 1'b1;
        bus.state  = a;
        tick();
        bus.state  = b;
        tick();
        bus.enable = 1'b0;
        for (int i = 0; i < 4; i++) send_word(w[i]);
        tick();
        total++; if (bus.done !== 1'b1 || bus.state_out !== model(a, w[0], w[1], w[2], w[3])) $display("FAIL b2b_result: done=%b got %h required %h", bus.done, bus.state_out, model(a, w[0], w[1], w[2], w[3])); else passed++;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.done) dones++;
        end
        total++; if (dones != 0) $display("FAIL b2b_extra_done: got %0d extra dones required 0", dones); else passed++;
        total++; if (bus.err !== ERR_EN) $display("FAIL b2b_err: got %b required %b", bus.err, ERR_EN); else passed++;
    endtask

    task automatic test_async_reset();
        logic [127:0] s2 = {$urandom, $urandom, $urandom, $urandom};
        logic [31:0]  w[4];
        for (int i = 0; i < 4; i++) w[i] = $urandom;
        bus.enable = 1'b1;
        bus.state  = ~s2;
        tick();
        bus.enable = 1'b0;
        send_word(32'hdeadbeef);
        send_word(32'hcafef00d);
        #2 rst = 1'b0;
        #1;
        total++; if (bus.state_out !== 128'h0 || bus.done !== 1'b0 || bus.busy !== 1'b0) $display("FAIL arst_immediate: state_out=%h done=%b busy=%b required 0/0/0", bus.state_out, bus.done, bus.busy); else passed++;
        total++; if (bus.err !== 1'b0 || bus.key_ready !== 1'b1) $display("FAIL arst_flags: err=%b key_ready=%b required 0/1", bus.err, bus.key_ready); else passed++;
        @(negedge clk);
        rst = 1'b1;
        prev_done = 1'b0;
        tick();
        send_word(w[0]);
        send_word(w[1]);
        bus.enable = 1'b1;
        bus.state  = s2;
        tick();
        bus.enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total++; if (bus.done !== 1'b0 || bus.busy !== 1'b1) $display("FAIL arst_partial: done=%b busy=%b required 0/1", bus.done, bus.busy); else passed++;
            tick();
        end
        send_word(w[2]);
        send_word(w[3]);
        tick();
        total++; if (bus.done !== 1'b1 || bus.state_out !== model(s2, w[0], w[1], w[2], w[3])) $display("FAIL arst_result: done=%b got %h required %h", bus.done, bus.state_out, model(s2, w[0], w[1], w[2], w[3])); else passed++;
        tick();
    endtask

    task automatic test_stall();
        logic [127:0] s = {$urandom, $urandom, $urandom, $urandom};
        logic [31:0]  w[4];
        for (int i = 0; i < 4; i++) w[i] = $urandom;
        for (int i = 0; i < 4; i++) send_word(w[i]);
        bus.key_valid = 1'b1;
        bus.key_word  = 32'h5a5a5a5a;
        for (int i = 0; i < 8; i++) tick();
        total++; if (bus.key_ready !== 1'b0 || bus.err !== 1'b0) $display("FAIL stall_8: key_ready=%b err=%b required 0/0", bus.key_ready, bus.err); else passed++;
        tick();
        tick();
        total++; if (bus.err !== ERR_EN) $display("FAIL stall_9: err=%b required %b", bus.err, ERR_EN); else passed++;
        bus.key_valid = 1'b0;
        bus.enable    = 1'b1;
        bus.state     = s;
        tick();
        bus.enable = 1'b0;
        tick();
        total++; if (bus.done !== 1'b1 || bus.state_out !== model(s, w[0], w[1], w[2], w[3])) $display("FAIL stall_result: done=%b got %h required %h", bus.done, bus.state_out, model(s, w[0], w[1], w[2], w[3])); else passed++;
        tick();
    endtask

    task automatic test_simultaneous();
        logic [127:0] s = {$urandom, $urandom, $urandom, $urandom};
        logic [31:0]  w[4];
        for (int i = 0; i < 4; i++) w[i] = $urandom;
        for (int i = 0; i < 3; i++) send_word(w[i]);
        bus.key_valid = 1'b1;
        bus.key_word  = w[3];
        bus.enable    = 1'b1;
        bus.state     = s;
        tick();
        bus.key_valid = 1'b0;
        bus.enable    = 1'b0;
        total++; if (bus.busy !== 1'b1 || bus.key_ready !== 1'b0 || bus.done !== 1'b0) $display("FAIL simul_apply: busy=%b key_ready=%b done=%b required 1/0/0", bus.busy, bus.key_ready, bus.done); else passed++;
        tick();
        total++; if (bus.done !== 1'b1 || bus.state_out !== model(s, w[0], w[1], w[2], w[3])) $display("FAIL simul_result: done=%b got %h required %h", bus.done, bus.state_out, model(s, w[0], w[1], w[2], w[3])); else passed++;
        tick();
    endtask

    task automatic test_random();
        for (int r = 0; r < 20; r++) begin
            logic [127:0] s = {$urandom, $urandom, $urandom, $urandom};
            logic [31:0]  w[4];
            int           en_delay = $urandom_range(0, 6);
            int           nw = 0;
            bit           en_sent = 1'b0;
            bit           got = 1'b0;
            for (int i = 0; i < 4; i++) w[i] = $urandom;
            for (int c = 0; c < 100 && !got; c++) begin
                bit acc;
                bus.enable    = !en_sent && c >= en_delay;
                bus.state     = s;
                bus.key_valid = nw < 4 && $urandom_range(0, 1) == 1;
                bus.key_word  = w[nw < 4 ? nw : 0];
                acc = bus.key_valid && bus.key_ready;
                if (bus.enable) en_sent = 1'b1;
                tick();
                if (acc) nw++;
                if (bus.done) begin
                    got = 1'b1;
                    total++; if (nw != 4 || bus.state_out !== model(s, w[0], w[1], w[2], w[3])) $display("FAIL rand_result[%0d]: words=%0d got %h required %h", r, nw, bus.state_out, model(s, w[0], w[1], w[2], w[3])); else passed++;
                end
            end
            bus.enable    = 1'b0;
            bus.key_valid = 1'b0;
            if (!got) begin
                total++;
                $display("FAIL rand_timeout[%0d]: done=0 required 1 within 100 cycles", r);
            end
        end
    endtask

    initial begin
        bus.state     = '0;
        bus.enable    = 1'b0;
        bus.key_word  = '0;
        bus.key_valid = 1'b0;
        test_reset();
        test_fips();
        test_state_first();
        test_key_reuse();
        test_back_to_back();
        test_async_reset();
        test_stall();
        test_simultaneous();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
